mips_store_buffer: RTL
======================

# mips_store_buffer

Write-posting store buffer between the pipelined MIPS core's memory stage and data memory. It accepts word stores (`memwrite`, `dataadr`, `writedata`) in one cycle, queues them in order, and drains them to data memory with a valid/ready handshake. This decouples the core from memory write latency. The core stalls only when the buffer is full. An optional forwarding port lets memory-stage loads see queued stores.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2
- `AW`, 32: address width
- `DW`, 32: data width
- `clk` in 1: clock; all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `memwrite` in 1: core store request this cycle
- `dataadr` in AW: store address (byte address, word-aligned)
- `writedata` in DW: store data
- `stall` out 1: store cannot be accepted this cycle
- `mem_we` out 1: head entry valid toward memory
- `mem_addr` out AW: head entry address
- `mem_wdata` out DW: head entry data
- `mem_ready` in 1: memory accepts head this cycle
- `ld_addr` in AW: load lookup address (forwarding build only)
- `ld_hit` out 1: a queued entry matches `ld_addr` (forwarding build only)
- `ld_data` out DW: data of youngest matching entry (forwarding build only)
- `empty` out 1: no entries queued

## Operation
- Circular FIFO with head pointer, tail pointer and count, each `$clog2(DEPTH)` or `$clog2(DEPTH)+1` bits wide. Pointers wrap modulo DEPTH.
- Push: `memwrite && count!=DEPTH`. Writes `{dataadr, writedata}` at tail, then tail+1.
- `stall = memwrite && count==DEPTH`, combinational. A pop in the same cycle does not free a slot for a push; a full buffer always stalls.
- Pop: `mem_we && mem_ready`. Head+1.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- `mem_we = (count!=0)`. `mem_addr`/`mem_wdata` come combinationally from the head entry. They hold stable while `mem_we && !mem_ready`.
- Stores drain strictly in program order. No coalescing; repeated stores to one address drain individually.
- Forwarding: compare `ld_addr[AW-1:2]` against all valid entries. `ld_hit`=any match. `ld_data` = the match nearest tail (youngest). On a miss, `ld_data`=0.
- A store pushed in cycle N is visible to forwarding from cycle N+1, not in cycle N.
- Reset is asynchronous and takes effect mid-drain. All entries are discarded with no write-back. `mem_we`, `stall`, `ld_hit` drop to 0 immediately.

## Timing
- Reset values: count=0, head=tail=0, `mem_we`=0, `stall`=0, `empty`=1, `ld_hit`=0, `ld_data`=0, `mem_addr`/`mem_wdata`=0. Entry storage is cleared to 0.
- Latency: store at edge N gives `mem_we`=1 after edge N; memory can accept at edge N+1. Minimum latency is 1 cycle; there is no bypass.
- Throughput with `mem_ready` held 1: one store per cycle indefinitely, no stall.
- `empty` and `mem_we` are complements. Both derive from registered count, so they are glitch-free after the edge.

## Configuration
- `STORE_BUF_FWD_EN`
  - Defined: forwarding comparators and the `ld_addr`/`ld_hit`/`ld_data` ports exist.
  - Undefined: the ports are absent and there is no comparator logic. The core must then stall loads until `empty`=1.

## Structure
- Shared package `mips_pkg`:
  - `sb_entry_t` struct `{addr, data}`
  - default `SB_DEPTH`
- No sub-module for FIFO control. One sub-module `sb_fwd_match` holds the youngest-match priority search, instantiated only under `STORE_BUF_FWD_EN`.

## Test plan
- Single store: after reset release, `memwrite`=1, addr 84, data 0xFFFF7F02, `mem_ready`=1. Expect `mem_we`=1, addr 84, data 0xFFFF7F02 exactly one cycle later, then `empty`=1.
- Back-pressure: `mem_ready`=0, issue 5 stores to addr 0,4,8,12,16. The first 4 are accepted. The 5th sees `stall`=1 and is held until the cycle after the first pop. Drain order is 0,4,8,12,16.
- Full with pop: count=4, `mem_ready`=1 and `memwrite`=1 in the same cycle. Expect `stall`=1, count becomes 3, and the store is accepted the next cycle.
- Forwarding (`STORE_BUF_FWD_EN`): queue stores to 82←0x11, 84←0x22, 84←0x33, with `mem_ready`=0. `ld_addr`=84 gives hit, data 0x33. `ld_addr`=80 gives hit, data 0x11 (same word, addr[1:0] ignored). `ld_addr`=88 gives miss, data 0.
- Wrap-around: 10 stores with `mem_ready` toggling every cycle. All 10 drain in order with correct data across pointer wrap.
- Reset mid-drain: 3 queued, `mem_ready`=0, assert `reset` low between edges. Outputs return to reset values without a clock edge. After release, no write from the old entries appears.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared types and defaults for the MIPS store buffer.
//             sb_entry_t holds one queued word store {addr, data}.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int SB_DEPTH = 4;   // default number of store-buffer entries
  localparam int SB_AW    = 32;  // address width of a queued entry
  localparam int SB_DW    = 32;  // data width of a queued entry

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module   : sb_fwd_match
//  Purpose  : Youngest-match search of the store buffer for load forwarding.
//             Compares the word address (bits AW-1:2) of a load against every
//             valid entry and returns the data of the match nearest the tail.
//  Ports    : entries_i  - full entry storage
//             head_i     - index of the oldest valid entry
//             count_i    - number of valid entries
//             ld_addr_i  - load lookup address
//             hit_o      - any valid entry matches
//             data_o     - youngest matching data, 0 on miss
//  Revision : 1.0  initial release
// ============================================================================
module sb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic [PW-1:0]         head_i,
  input  logic [CW-1:0]         count_i,
  input  logic [AW-1:0]         ld_addr_i,
  output logic                  hit_o,
  output logic [DW-1:0]         data_o
);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest; a later match overrides an earlier one,
  // so the final value is the youngest store to that word.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      // Shifting the XOR drops byte-offset bits so only word addresses compare.
      if ((CW'(i) < count_i) && (((entries_i[idx].addr ^ ld_addr_i) >> 2) == '0)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : mips_store_buffer
//  Purpose  : Write-posting store buffer between the MIPS memory stage and
//             data memory. In-order circular FIFO, drained with a
//             valid/ready handshake. The core stalls only when full.
//  Config   : STORE_BUF_FWD_EN - when defined, adds the load-forwarding
//             ports ld_addr/ld_hit/ld_data and the sb_fwd_match search.
//  Ports    : clk, reset (async, active-low)
//             memwrite/dataadr/writedata - store request from the core
//             stall     - store cannot be accepted this cycle
//             mem_we/mem_addr/mem_wdata/mem_ready - drain handshake
//             empty     - no entries queued
//  Note     : AW/DW must equal the entry widths in mips_pkg.
//  Revision : 1.0  initial release
// ============================================================================
module mips_store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          empty
`ifdef STORE_BUF_FWD_EN
  ,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] buf_q;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic w_full;
  logic w_push;
  logic w_pop;

  // A pop in the same cycle never frees a slot for a push: fullness is
  // judged purely on the registered count.
  assign w_full = (count_q == CW'(DEPTH));
  assign w_push = memwrite && !w_full;
  assign w_pop  = (count_q != '0) && mem_ready;

  always_comb begin
    head_d  = w_pop  ? head_q + PW'(1) : head_q;
    tail_d  = w_push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Async reset discards every queued store, including one being drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (w_push) begin
        buf_q[tail_q] <= '{addr: dataadr, data: writedata};
      end
    end
  end

  assign stall     = memwrite && w_full;
  assign mem_we    = (count_q != '0);
  assign empty     = (count_q == '0);
  assign mem_addr  = buf_q[head_q].addr;
  assign mem_wdata = buf_q[head_q].data;

`ifdef STORE_BUF_FWD_EN
  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entries_i (buf_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .ld_addr_i (ld_addr),
    .hit_o     (ld_hit),
    .data_o    (ld_data)
  );
`endif

endmodule
`default_nettype wire
